// File: rtl/date_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : date_pkg
//  Description : Shared calendar constants and FSM state encoding for the
//                day-of-year to month/day decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package date_pkg;

    // Month numbers, 1-based as displayed
    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    // Month and year lengths
    localparam logic [4:0] DAYS_LONG      = 5'd31;
    localparam logic [4:0] DAYS_SHORT     = 5'd30;
    localparam logic [4:0] DAYS_FEB       = 5'd28;
    localparam logic [4:0] DAYS_FEB_LEAP  = 5'd29;
    localparam logic [8:0] DAYS_YEAR      = 9'd365;
    localparam logic [8:0] DAYS_LEAP_YEAR = 9'd366;

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WALK  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage : date_pkg
`default_nettype wire

// File: rtl/days_in_month_lut.sv
`default_nettype none
// ============================================================================
//  Module      : days_in_month_lut
//  Description : Combinational month-length lookup. Returns 0 for month
//                numbers outside 1..12.
//  Revision    : 1.0 - initial release
// ============================================================================
module days_in_month_lut
    import date_pkg::*;
(
    input  logic [3:0] i_month,
    input  logic       i_leap,
    output logic [4:0] o_len
);

    // Month number to length, February depending on leap status
    always_comb begin
        o_len = 5'd0;
        case (i_month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: o_len = DAYS_LONG;
            APR, JUN, SEP, NOV:                o_len = DAYS_SHORT;
            FEB:                               o_len = i_leap ? DAYS_FEB_LEAP : DAYS_FEB;
            default:                           o_len = 5'd0;
        endcase
    end

endmodule : days_in_month_lut
`default_nettype wire

// File: rtl/date_from_day_of_year.sv
`default_nettype none
// ============================================================================
//  Module      : date_from_day_of_year
//  Description : Iterative decoder from (year, day-of-year) to
//                (month, day-of-month). Walks one month per clock, subtracting
//                month lengths until the remainder fits in the current month.
//  Revision    : 1.0 - initial release
// ============================================================================
module date_from_day_of_year
    import date_pkg::*;
#(
    parameter int YEAR_W = 12,
    parameter int DOY_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [YEAR_W-1:0] year,
    input  logic [DOY_W-1:0]  doy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        month,
    output logic [4:0]        day
);

    localparam logic [DOY_W-1:0] C_MAX_NORMAL = DOY_W'(DAYS_YEAR);
    localparam logic [DOY_W-1:0] C_MAX_LEAP   = DOY_W'(DAYS_LEAP_YEAR);

    state_t           r_state;
    logic             r_leap;
    logic [DOY_W-1:0] r_rem;
    logic [3:0]       r_m;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [3:0]       r_month;
    logic [4:0]       r_day;

    logic [4:0]       w_len;
    logic [DOY_W-1:0] w_len_ext;
    logic [DOY_W-1:0] w_max_doy;
    logic             w_unused_year;

    // Only the low two year bits matter under the 4-year leap rule
    assign w_unused_year = ^year[YEAR_W-1:2];

    assign w_len_ext = DOY_W'(w_len);
    assign w_max_doy = r_leap ? C_MAX_LEAP : C_MAX_NORMAL;

    days_in_month_lut u_lut (
        .i_month (r_m),
        .i_leap  (r_leap),
        .o_len   (w_len)
    );

    // Decoder FSM: capture, range check, month walk, completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_leap  <= 1'b0;
            r_rem   <= '0;
            r_m     <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_month <= 4'd0;
            r_day   <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_leap  <= (year[1:0] == 2'b00);
                        r_rem   <= doy;
                        r_busy  <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if ((r_rem == '0) || (r_rem > w_max_doy)) begin
                        r_err   <= 1'b1;
                        r_month <= 4'd0;
                        r_day   <= 5'd0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_m     <= JAN;
                        r_state <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    // Range check guarantees the remainder fits by December
                    if (r_rem <= w_len_ext) begin
                        r_month <= r_m;
                        r_day   <= r_rem[4:0];
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_rem <= r_rem - w_len_ext;
                        r_m   <= r_m + 4'd1;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The walk must never run past December
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_WALK)) begin
            assert (r_m <= DEC);
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign month = r_month;
    assign day   = r_day;

endmodule : date_from_day_of_year
`default_nettype wire

// File: tb/tb_date_from_day_of_year.sv
`default_nettype none
// ============================================================================
//  Module      : tb_date_from_day_of_year
//  Description : Self-checking bench for the day-of-year decoder using an
//                expected-result queue filled at start and drained at done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_date_from_day_of_year;

    localparam int YEAR_W = 12;
    localparam int DOY_W  = 9;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [YEAR_W-1:0] year;
    logic [DOY_W-1:0]  doy;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        month;
    logic [4:0]        day;

    typedef struct {
        int m;
        int d;
        bit e;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int       n_vec;
    int       n_err;
    logic [3:0] last_m;
    logic [4:0] last_d;
    logic       last_e;

    date_from_day_of_year #(
        .YEAR_W (YEAR_W),
        .DOY_W  (DOY_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .year  (year),
        .doy   (doy),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .month (month),
        .day   (day)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cumulative days before each month, then find the month
    function automatic exp_t model(input int yr, input int d);
        exp_t r;
        int   cum [13];
        int   lens [12];
        bit   leap;
        leap = (yr % 4) == 0;
        lens = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (leap) lens[1] = 29;
        cum[0] = 0;
        for (int i = 0; i < 12; i++) cum[i+1] = cum[i] + lens[i];
        r = '{0, 0, 1'b1, 2};
        if (d >= 1 && d <= cum[12]) begin
            for (int i = 0; i < 12; i++) begin
                if (d > cum[i] && d <= cum[i+1]) begin
                    r.m   = i + 1;
                    r.d   = d - cum[i];
                    r.e   = 1'b0;
                    r.cyc = 2 + (i + 1);
                end
            end
        end
        return r;
    endfunction

    // One decode: push expectation, pulse start, watch every cycle until done
    task automatic run_op(input string name, input int yr, input int d,
                          input int em, input int ed, input bit ee, input int ecyc,
                          input bit repulse);
        exp_t e;
        int   k;
        bit   seen;
        bit   busy_bad;
        e = '{em, ed, ee, ecyc};
        sb.push_back(e);
        @(posedge clk); #1;
        year  = YEAR_W'(yr);
        doy   = DOY_W'(d);
        start = 1'b1;
        k        = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                start = 1'b0;
                year  = YEAR_W'($urandom);
                doy   = DOY_W'($urandom);
                n_vec++;
                if ({month, day, err} !== {last_m, last_d, last_e}) begin
                    n_err++;
                    $display("FAIL %s hold: got m=%0d d=%0d e=%0b want m=%0d d=%0d e=%0b",
                             name, month, day, err, last_m, last_d, last_e);
                end
            end
            if (repulse && k == 3) start = 1'b1;
            if (repulse && k == 4) start = 1'b0;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                n_vec++;
                if (k != e.cyc) begin
                    n_err++;
                    $display("FAIL %s latency: got cycle %0d want %0d", name, k, e.cyc);
                end
                n_vec++;
                if (month !== 4'(e.m)) begin
                    n_err++;
                    $display("FAIL %s month: got %0d want %0d", name, month, e.m);
                end
                n_vec++;
                if (day !== 5'(e.d)) begin
                    n_err++;
                    $display("FAIL %s day: got %0d want %0d", name, day, e.d);
                end
                n_vec++;
                if (err !== e.e) begin
                    n_err++;
                    $display("FAIL %s err: got %0b want %0b", name, err, e.e);
                end
                last_m = 4'(e.m);
                last_d = 5'(e.d);
                last_e = e.e;
                // A start in the done cycle must be dropped
                if (repulse) start = 1'b1;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", name, k);
            void'(sb.pop_front());
        end
        n_vec++;
        if (busy_bad) begin
            n_err++;
            $display("FAIL %s busy: dropped low before done, want high cycles 1..%0d", name, ecyc);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: got busy=%0b done=%0b want 0/0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        year  = '0;
        doy   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, err, month, day} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%0b done=%0b err=%0b m=%0d d=%0d want all 0",
                     busy, done, err, month, day);
        end
        rst_n  = 1'b1;
        last_m = 4'd0;
        last_d = 5'd0;
        last_e = 1'b0;
    endtask

    task automatic test_feb();
        run_op("feb_end_2015", 2015, 59, 2, 28, 1'b0, 4, 1'b0);
    endtask

    task automatic test_leap();
        run_op("leap_day_2016", 2016, 60, 2, 29, 1'b0, 4, 1'b0);
        run_op("mar1_2015",     2015, 60, 3,  1, 1'b0, 5, 1'b0);
    endtask

    task automatic test_year_end();
        run_op("dec31_2016",    2016, 366, 12, 31, 1'b0, 14, 1'b0);
        run_op("doy366_2015",   2015, 366,  0,  0, 1'b1,  2, 1'b0);
    endtask

    task automatic test_bounds();
        run_op("doy0",          2020,   0, 0, 0, 1'b1, 2, 1'b0);
        run_op("doy1_2015",     2015,   1, 1, 1, 1'b0, 3, 1'b0);
        run_op("doy1_2016",     2016,   1, 1, 1, 1'b0, 3, 1'b0);
        run_op("doy367_2016",   2016, 367, 0, 0, 1'b1, 2, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op("oct27_repulse", 2015, 300, 10, 27, 1'b0, 12, 1'b1);
    endtask

    task automatic test_reset_abort();
        bit done_seen;
        @(posedge clk); #1;
        year  = YEAR_W'(2015);
        doy   = DOY_W'(200);
        start = 1'b1;
        done_seen = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done === 1'b1) done_seen = 1'b1;
            if (k == 6) rst_n = 1'b0;
            if (k == 7) rst_n = 1'b1;
        end
        n_vec++;
        if ({busy, done, err, month, day} !== 12'd0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%0b done=%0b err=%0b m=%0d d=%0d want all 0",
                     busy, done, err, month, day);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        n_vec++;
        if (done_seen) begin
            n_err++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        last_m = 4'd0;
        last_d = 5'd0;
        last_e = 1'b0;
        run_op("after_abort_jul19", 2015, 200, 7, 19, 1'b0, 9, 1'b0);
    endtask

    task automatic test_random();
        exp_t e;
        int   yr;
        int   d;
        for (int i = 0; i < 10; i++) begin
            yr = int'($urandom_range(1901, 2099));
            d  = int'($urandom_range(0, 367));
            e  = model(yr, d);
            run_op("random", yr, d, e.m, e.d, e.e, e.cyc, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_a", 2024, 244, 8, 31, 1'b0, 10, 1'b0);
        run_op("b2b_b", 2023, 335, 12, 1, 1'b0, 14, 1'b0);
        run_op("b2b_c", 2023,  32, 2,  1, 1'b0,  4, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_feb();
        test_leap();
        test_year_end();
        test_bounds();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_date_from_day_of_year
`default_nettype wire
